bta_reduce_seq: RTL and testbench
=================================

# bta_reduce_seq

Sequential controller for the multi-operand binary-tree adder family. It accepts a frame of N operands over a valid/ready stream and stores them in a slot register file. It then schedules the N−1 pairwise additions of a binary reduction tree, one per cycle, on a single shared adder. The full-precision sum is presented on a valid/ready output. This block is the area-lean, time-multiplexed counterpart of the fully parallel tree adders, for use where operand throughput is low.

## Interface
- N, 8, operands per frame; power of two, N ≥ 2; LG = log2(N)
- M, 16, operand width in bits; result width W = M + LG
- clk  in  1  clock; all registers update on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand present on in_data
- in_ready  out  1  block accepts an operand this cycle
- in_data  in  M  unsigned operand
- out_valid  out  1  out_sum holds a completed frame result
- out_ready  in  1  consumer accepts out_sum
- out_sum  out  W  unsigned sum of the N operands of the frame
- busy  out  1  high in REDUCE or DONE state

## Operation
- Slot file: N registers slot[0..N−1], W bits each. Operands are zero-extended from M to W bits.
- FSM states: LOAD, REDUCE, DONE. Reset state is LOAD.
- LOAD
  - in_ready = 1.
  - Each cycle with in_valid && in_ready writes slot[ld_cnt] and increments ld_cnt.
  - The transfer with ld_cnt = N−1 moves the FSM to REDUCE and clears lvl = 1 and k = 0.
  - in_valid gaps stall LOAD without limit.
- REDUCE
  - in_ready = 0.
  - Each cycle performs one addition: slot[k] ← slot[2k] + slot[2k+1].
  - The in-place order is safe: the write index k never exceeds the read indices.
  - When k = (N >> lvl) − 1: k ← 0 and lvl ← lvl + 1. Otherwise k ← k + 1.
  - The addition with lvl = LG, k = 0 is the final one. The FSM moves to DONE.
  - Total additions = N−1, one per cycle.
- DONE
  - out_valid = 1. out_sum = slot[0], held stable while out_valid && !out_ready.
  - When out_valid && out_ready: FSM → LOAD and ld_cnt ← 0.
  - in_ready rises the next cycle. There is no same-cycle bypass into LOAD.
- Arithmetic
  - Unsigned adds at W bits.
  - The sum of N values each < 2^M is < 2^W, so overflow is impossible and there is no carry output.
- out_sum is driven from slot[0] in every state. It is meaningful only while out_valid = 1.
- Reset (async, any state, including mid-LOAD or mid-REDUCE)
  - FSM → LOAD; ld_cnt, lvl and k → 0; all slots → 0.
  - The partial frame is discarded and not resumed.
- Reset values: in_ready = 1, out_valid = 0, out_sum = 0, busy = 0.

## Timing
- in_ready, out_valid and busy are decoded from the registered FSM state only. There is no combinational path from in_valid or out_ready to any output.
- Latency: the last operand is accepted at edge e0. Additions occur at edges e1..e(N−1). out_valid is high after edge e(N−1).
  - N = 8: out_valid rises 7 cycles after the last accept.
- Minimum frame period with no stalls: N (load) + N−1 (reduce) + 1 (DONE handshake) = 2N cycles. N = 8: 16 cycles.
- out_ready held low: DONE holds indefinitely and out_sum stays constant.
- Operands presented while in_ready = 0 are ignored and not stored.
- Critical path: one W-bit adder plus slot read muxes. The adder must close timing in a single cycle.

## Test plan
- Basic frame (N=8, M=16): operands 1,2,…,8 streamed back-to-back → out_valid 7 cycles after the 8th accept, out_sum = 36, busy high for exactly 8 cycles.
- Max values: eight operands of 0xFFFF → out_sum = 0x7FFF8 (19 bits), no truncation.
- Backpressure: complete a frame with out_ready low for 5 cycles → out_valid stays 1, out_sum stable, in_ready = 0 and in_valid pulses ignored. Raising out_ready → in_ready = 1 the next cycle.
- Input gaps: operands 10,0,20,0,30,0,40,0 with random 0–3 cycle in_valid gaps → out_sum = 100, and ld_cnt advances only on handshakes.
- Reset mid-REDUCE: assert rst 3 cycles into REDUCE → immediately out_valid = 0, in_ready = 1, busy = 0. The next frame of eight 0x0001 operands → out_sum = 8, with no residue from the aborted frame.
- Back-to-back frames with out_ready tied 1: frames {1..8} then {100×8} → results 36 and 800, each frame period exactly 16 cycles.

Source files
------------

// File: rtl/bta_reduce_seq_if.sv
// Operand-in / sum-out stream bundle for the sequential binary-tree reducer.
// N and M must match the parameters of the attached bta_reduce_seq instance.
interface bta_reduce_seq_if #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 16
);
    localparam int unsigned LG = $clog2(N);
    localparam int unsigned W  = M + LG;

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/bta_reduce_seq.sv
// Time-multiplexed N-operand adder: loads a frame into a slot file, then folds
// it pairwise in place on one shared W-bit adder, one addition per cycle.
module bta_reduce_seq #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 16
) (
    input  logic            clk,
    input  logic            rst,
    bta_reduce_seq_if.slave bus
);
    localparam int unsigned LG  = $clog2(N);
    localparam int unsigned W   = M + LG;
    localparam int unsigned LVW = $clog2(LG + 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [LG-1:0]   ld_cnt;
    logic [LG-1:0]   k;
    logic [LVW-1:0]  lvl;
    logic [W-1:0]    slot [N];

    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            in_ready_d;
    logic            out_valid_d;
    logic            busy_d;

    logic            accept;
    logic            last_load;
    logic            handoff;
    logic            reducing;
    logic            final_add;
    logic            lvl_end;
    logic [LG-1:0]   k_last;
    logic [LG-1:0]   rd_a;
    logic [LG-1:0]   rd_b;
    logic [W-1:0]    add_sum;

    assign accept    = in_ready_q && bus.in_valid;
    assign last_load = accept && (ld_cnt == LG'(N - 1));
    assign handoff   = out_valid_q && bus.out_ready;
    assign reducing  = (state == ST_REDUCE);

    // Last pair index of the current tree level: (N >> lvl) - 1.
    assign k_last    = LG'((N >> lvl) - 1);
    assign lvl_end   = (k == k_last);
    assign final_add = reducing && (lvl == LVW'(LG)) && (k == '0);

    // Children of node k live at 2k and 2k+1; writing slot[k] never clobbers an unread operand.
    assign rd_a      = LG'({k, 1'b0});
    assign rd_b      = LG'({k, 1'b1});
    assign add_sum   = slot[rd_a] + slot[rd_b];

    // State register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_LOAD;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (last_load) begin
                    state_nxt = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (final_add) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (handoff) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Status outputs decoded from the upcoming state so they are flop-driven.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_nxt)
            ST_LOAD:   in_ready_d  = 1'b1;
            ST_REDUCE: busy_d      = 1'b1;
            ST_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default:   in_ready_d  = 1'b1;
        endcase
    end

    // Load counter and reduction schedule (level, pair index).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            k      <= '0;
            lvl    <= '0;
        end else begin
            if (accept) begin
                ld_cnt <= last_load ? '0 : ld_cnt + LG'(1);
                if (last_load) begin
                    lvl <= LVW'(1);
                    k   <= '0;
                end
            end else if (reducing) begin
                if (final_add) begin
                    lvl <= '0;
                    k   <= '0;
                end else if (lvl_end) begin
                    lvl <= lvl + LVW'(1);
                    k   <= '0;
                end else begin
                    k   <= k + LG'(1);
                end
            end else if (handoff) begin
                ld_cnt <= '0;
            end
        end
    end

    // Slot file: operand capture during LOAD, in-place partial sums during REDUCE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                slot[i] <= '0;
            end
        end else if (accept) begin
            slot[ld_cnt] <= W'(bus.in_data);
        end else if (reducing) begin
            slot[k] <= add_sum;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_sum   = slot[0];

endmodule

// File: tb/tb_bta_reduce_seq.sv
// Directed bench for bta_reduce_seq: vector table of frames plus hand-written
// backpressure, reset-abort and back-to-back sequences.
module tb_bta_reduce_seq;
    localparam int unsigned N = 8;
    localparam int unsigned M = 16;
    localparam int unsigned W = 19;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   last_acc = 0;
    int   first_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bta_reduce_seq_if #(.N(N), .M(M)) bus ();
    bta_reduce_seq #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0][15:0] ops;
        logic [7:0][1:0]  gap;
        logic [W-1:0]     exp;
    } vec_t;

    vec_t vec [4];
    vec_t vb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until the edge that accepts it.
    task automatic send(input logic [15:0] v);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (!bus.in_ready && t < 64) begin
            tick();
            t++;
        end
        check("send_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        last_acc     = cyc;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
    endtask

    // With out_ready high: check latency, sum, busy duration and return to LOAD.
    task automatic wait_result(input logic [W-1:0] exp, input string tag);
        int b;
        int t;
        b = 0;
        t = 0;
        if (bus.busy) b++;
        while (!bus.out_valid && t < 64) begin
            tick();
            t++;
            if (bus.busy) b++;
        end
        check({tag, "_latency"}, 32'(cyc - last_acc), 32'd7);
        check({tag, "_sum"}, 32'(bus.out_sum), 32'(exp));
        tick();
        check({tag, "_busy_cycles"}, 32'(b), 32'd8);
        check({tag, "_post_rdy_vld_busy"}, 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'(3'b100));
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < int'(v.gap[i]); g++) begin
                bus.in_data = 16'($urandom);
                tick();
            end
            send(v.ops[i]);
            if (i == 0) first_acc = last_acc;
        end
        wait_result(v.exp, tag);
    endtask

    initial begin
        int t;
        int fa;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        vec[0] = '0;
        for (int i = 0; i < 8; i++) vec[0].ops[i] = 16'(i + 1);
        vec[0].exp = 19'd36;
        vec[1] = '0;
        for (int i = 0; i < 8; i++) vec[1].ops[i] = 16'hFFFF;
        vec[1].exp = 19'h7FFF8;
        vec[2].ops = {16'd0, 16'd40, 16'd0, 16'd30, 16'd0, 16'd20, 16'd0, 16'd10};
        vec[2].gap = {2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
        vec[2].exp = 19'd100;
        vec[3].ops = {16'hFFFF, 16'h0002, 16'h7FFF, 16'h00FF, 16'h8000, 16'hABCD, 16'h0001, 16'h1234};
        vec[3].gap = '0;
        vec[3].exp = 19'h2BF01;

        for (int i = 0; i < 4; i++) run_frame(vec[i], $sformatf("vec%0d", i));

        // Backpressure: hold DONE for five cycles with stray in_valid pulses.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(vec[0].ops[i]);
        t = 0;
        while (!bus.out_valid && t < 64) begin
            tick();
            t++;
        end
        check("bp_latency", 32'(cyc - last_acc), 32'd7);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_sum", 32'(bus.out_sum), 32'd36);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = (c % 2 == 0);
            bus.in_data  = 16'h5555;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_hold_sum", 32'(bus.out_sum), 32'd36);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_rdy_vld", 32'({bus.in_ready, bus.out_valid}), 32'(2'b10));
        run_frame(vec[3], "bp_next");

        // Reset three cycles into REDUCE, then a clean frame of ones.
        for (int i = 0; i < 8; i++) send(vec[1].ops[i]);
        tick();
        tick();
        tick();
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out_sum", 32'(bus.out_sum), 32'd0);
        #2;
        rst = 1'b0;
        vb = '0;
        for (int i = 0; i < 8; i++) vb.ops[i] = 16'h0001;
        vb.exp = 19'd8;
        run_frame(vb, "after_abort");

        // Back-to-back frames: 16-cycle period between first accepts.
        run_frame(vec[0], "b2b_a");
        fa = first_acc;
        for (int i = 0; i < 8; i++) vb.ops[i] = 16'd100;
        vb.exp = 19'd800;
        run_frame(vb, "b2b_b");
        check("b2b_period", 32'(first_acc - fa), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
